// File: rtl/kp_matrix_scan_pkg.sv
// kp_pkg: shared types and helpers for the keypad matrix scanner.
//   kp_state_e    - scanner FSM states
//   col_drive_bit - one bit of the walking-zero column drive pattern
package kp_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // Column c drives SCAN[cols-1-c] low; every other bit idles high.
  // Written per bit so callers of any width can build the vector in a loop.
  function automatic logic col_drive_bit(input int unsigned bit_i,
                                         input int unsigned col,
                                         input int unsigned cols);
    return (bit_i + col) != (cols - 1);
  endfunction

endpackage

// File: rtl/kp_matrix_scan_if.sv
// kp_matrix_scan_if: keypad scanner signal bundle.
//   en        scan enable (consumer -> scanner)
//   row_in    raw active-low row lines, asynchronous
//   scan      walking-zero column drive
//   col_idx   current column index
//   key_valid debounced key code available
//   key_code  row_index*COLS + column
//   key_ack   consumer accepts key_code
//   key_err   one-cycle pulse on a rejected multi-key column
// Modports: master = consumer/board side, slave = scanner.
interface kp_matrix_scan_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CW = $clog2(COLS);
  localparam int KW = $clog2(ROWS*COLS);

  logic            en;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] scan;
  logic [CW-1:0]   col_idx;
  logic            key_valid;
  logic [KW-1:0]   key_code;
  logic            key_ack;
  logic            key_err;

  modport master (
    output en, row_in, key_ack,
    input  scan, col_idx, key_valid, key_code, key_err
  );

  modport slave (
    input  en, row_in, key_ack,
    output scan, col_idx, key_valid, key_code, key_err
  );
endinterface

// File: rtl/kp_matrix_scan_sync.sv
// kp_sync: parametrised-width 2-flop synchronizer with a configurable
// reset value.
//   clk, rst_n  clock, asynchronous active-low reset
//   d_i         asynchronous input bus
//   q_o         synchronized bus, two cycles later
module kp_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/kp_matrix_scan.sv
// kp_matrix_scan: keypad matrix scanner with debounce and key handshake.
//   clk, rst_n  clock, asynchronous active-low reset
//   kp (slave)  en/row_in/key_ack in; scan/col_idx/key_valid/key_code/key_err out
// Scans one column at a time (walking zero), debounces any low row,
// issues one code per press and waits for a full release before scanning on.
// Build option: define KP_GHOST_REJECT_EN to reject columns with more than
// one low row (key_err pulse, no code); otherwise the lowest row wins and
// key_err stays low.
module kp_matrix_scan
  import kp_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1,
  parameter int DEBOUNCE = 4
) (
  input logic             clk,
  input logic             rst_n,
  kp_matrix_scan_if.slave kp
);

  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int KW  = $clog2(ROWS*COLS);
  localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  kp_state_e       state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DVW-1:0]  div_q, div_d;
  logic [DBW-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0] snap_q, snap_d;
  logic [KW-1:0]   code_q, code_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [ROWS-1:0] row_s;
  logic [RW-1:0]   row_idx;
  logic [KW-1:0]   new_code;
  logic [COLS-1:0] scan_w;
  logic            reject;

  // Rows idle high, so the synchronizer resets to all ones.
  kp_sync #(
    .W       (ROWS),
    .RST_VAL ({ROWS{1'b1}})
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (kp.row_in),
    .q_o   (row_s)
  );

  // Lowest-index low row of the snapshot (descending loop, last hit wins).
  always_comb begin
    row_idx = '0;
    for (int i = ROWS-1; i >= 0; i--) begin
      if (!snap_q[i]) row_idx = RW'(i);
    end
  end

  assign new_code = KW'(row_idx) * KW'(COLS) + KW'(col_q);

`ifdef KP_GHOST_REJECT_EN
  int low_n;
  always_comb begin
    low_n = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (!snap_q[i]) low_n = low_n + 1;
    end
  end
  assign reject = (low_n > 1);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    code_d  = code_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        // A pressed row wins over scan advance: the column stays put.
        if (!(&row_s)) begin
          state_d = ST_DEBOUNCE;
          snap_d  = row_s;
          cnt_d   = '0;
        end else if (kp.en) begin
          if (div_q == DVW'(SCAN_DIV-1)) begin
            div_d = '0;
            col_d = (col_q == CW'(COLS-1)) ? '0 : col_q + 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (row_s != snap_q) begin
          state_d = ST_SCAN;
        end else if (cnt_q == DBW'(DEBOUNCE-1)) begin
          if (reject) begin
            err_d   = 1'b1;
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            code_d  = new_code;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (valid_q && kp.key_ack) begin
          valid_d = 1'b0;
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        // Need DEBOUNCE consecutive all-high cycles; any low row restarts.
        if (!(&row_s)) begin
          cnt_d = '0;
        end else if (cnt_q == DBW'(DEBOUNCE-1)) begin
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '1;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Column drive decoded straight from the index register so reset shows
  // on the pins without waiting for an edge.
  always_comb begin
    scan_w = '1;
    for (int i = 0; i < COLS; i++) begin
      scan_w[i] = col_drive_bit(i, 32'(col_q), COLS);
    end
  end

  assign kp.scan      = scan_w;
  assign kp.col_idx   = col_q;
  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.key_err   = err_q;

endmodule

// File: tb/tb_kp_matrix_scan.sv
// tb_kp_matrix_scan: directed bench for kp_matrix_scan with
// ROWS=4, COLS=4, SCAN_DIV=2, DEBOUNCE=4. Honours KP_GHOST_REJECT_EN.
module tb_kp_matrix_scan;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] scan_tab [1:9];

  always #5 clk = ~clk;

  kp_matrix_scan_if #(.ROWS(4), .COLS(4)) kif ();

  kp_matrix_scan #(
    .ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input int c);
    for (int i = 0; i < 40 && 32'(kif.col_idx) != c; i++) step(1);
    chk("wait_col", 32'(kif.col_idx), c);
  endtask

  // Park the scan on column c, press 'rows', return at the cycle the
  // debounced result becomes visible (7 edges after the press).
  task automatic press(input int c, input logic [3:0] rows);
    wait_col(c);
    kif.en     = 1'b0;
    kif.row_in = rows;
    step(6);
    chk("pre_valid", 32'(kif.key_valid), 0);
    chk("pre_err",   32'(kif.key_err),   0);
    step(1);
  endtask

  initial begin
    scan_tab = '{4'b0111, 4'b1011, 4'b1011, 4'b1101, 4'b1101,
                 4'b1110, 4'b1110, 4'b0111, 4'b0111};
    rst_n       = 1'b0;
    kif.en      = 1'b0;
    kif.row_in  = 4'hF;
    kif.key_ack = 1'b0;
    #3;
    chk("rst_scan",  32'(kif.scan),      32'h7);
    chk("rst_col",   32'(kif.col_idx),   0);
    chk("rst_valid", 32'(kif.key_valid), 0);
    chk("rst_code",  32'(kif.key_code),  0);
    chk("rst_err",   32'(kif.key_err),   0);

    // Idle scan, two cycles per column
    step(2);
    rst_n  = 1'b1;
    kif.en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk($sformatf("scan_k%0d", k), 32'(kif.scan), 32'(scan_tab[k]));
    end

    // Row 2 on column 1 -> code 9, held until ack
    press(1, 4'b1011);
    chk("key_valid", 32'(kif.key_valid), 1);
    chk("key_code",  32'(kif.key_code),  9);
    chk("key_err",   32'(kif.key_err),   0);
    kif.en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("hold_valid", 32'(kif.key_valid), 1);
      chk("hold_code",  32'(kif.key_code),  9);
      chk("hold_scan",  32'(kif.scan),      32'hB);
    end
    kif.key_ack = 1'b1;
    step(1);
    chk("ack_valid", 32'(kif.key_valid), 0);
    kif.key_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("held_no_repeat", 32'(kif.key_valid), 0);
    end
    kif.row_in = 4'hF;
    step(7);
    chk("rel_col_r7", 32'(kif.col_idx), 1);
    step(1);
    chk("rel_col_r8", 32'(kif.col_idx), 2);

    // Two-cycle glitch on row 0: no code, column frozen then resumes
    kif.row_in = 4'b1110;
    step(2);
    kif.row_in = 4'hF;
    chk("gl_col_g2", 32'(kif.col_idx), 3);
    for (int i = 3; i <= 5; i++) begin
      step(1);
      chk($sformatf("gl_col_g%0d", i), 32'(kif.col_idx), 3);
      chk("gl_valid", 32'(kif.key_valid), 0);
    end
    step(1);
    chk("gl_col_g6", 32'(kif.col_idx), 3);
    step(1);
    chk("gl_col_g7", 32'(kif.col_idx), 0);

    // Rows 0 and 3 on column 2
    press(2, 4'b0110);
`ifdef KP_GHOST_REJECT_EN
    chk("ghost_err",   32'(kif.key_err),   1);
    chk("ghost_valid", 32'(kif.key_valid), 0);
    step(1);
    chk("ghost_err_1", 32'(kif.key_err),   0);
    chk("ghost_valid", 32'(kif.key_valid), 0);
`else
    chk("ghost_valid", 32'(kif.key_valid), 1);
    chk("ghost_code",  32'(kif.key_code),  2);
    chk("ghost_err",   32'(kif.key_err),   0);
    kif.key_ack = 1'b1;
    step(1);
    kif.key_ack = 1'b0;
    chk("ghost_ack", 32'(kif.key_valid), 0);
`endif
    kif.row_in = 4'hF;
    step(8);
    kif.en = 1'b1;

    // Reset in HOLD drops the code without a clock edge
    press(3, 4'b1110);
    chk("r_valid", 32'(kif.key_valid), 1);
    chk("r_code",  32'(kif.key_code),  3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(kif.key_valid), 0);
    chk("ar_scan",  32'(kif.scan),      32'h7);
    chk("ar_col",   32'(kif.col_idx),   0);
    chk("ar_code",  32'(kif.key_code),  0);
    kif.row_in = 4'hF;
    step(1);
    rst_n       = 1'b1;
    kif.en      = 1'b1;
    kif.key_ack = 1'b1;   // ack with nothing pending is ignored
    step(1);
    chk("post_scan1", 32'(kif.scan), 32'h7);
    step(1);
    chk("post_scan2", 32'(kif.scan), 32'hB);
    step(8);
    chk("post_valid", 32'(kif.key_valid), 0);
    kif.key_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
